// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock with a registered ripple carry.
// Latency: result valid NCH cycles after the accept edge; one op per NCH+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [KW-1:0]      k_q, k_d;

    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic [CHUNK:0]     chunk_res;
    logic [WIDTH-1:0]   res_full;

    always_comb begin
        chunk_a  = '0;
        chunk_b  = '0;
        res_full = psum_q;
        for (int i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a = opa_q[i*CHUNK +: CHUNK];
                chunk_b = opb_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                res_full[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        psum_d    = psum_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract as a + ~b + 1, so the borrow shows up as cout=0.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    psum_d  = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                psum_d  = res_full;
                carry_d = chunk_res[CHUNK];
                if (k_q == KW'(NCH - 1)) begin
                    sum_d   = res_full;
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &
                              (res_full[WIDTH-1] != opa_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4): vector table plus handshake/reset sequences.
module tb_chunked_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int failed = 0;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, then count cycles up to out_valid; leaves the DUT in DONE.
    task automatic start_and_wait(input vec_t v);
        int cyc;
        chk({v.name, "_rdy_idle"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            chk({v.name, "_rdy_run"}, 32'(in_ready), 32'd0);
            step();
            cyc++;
        end
        chk({v.name, "_latency"}, 32'(cyc), 32'(NCH));
    endtask

    task automatic run_vec(input vec_t v);
        start_and_wait(v);
        chk({v.name, "_sum"},  32'(sum),  32'(v.exp_sum));
        chk({v.name, "_cout"}, 32'(cout), 32'(v.exp_cout));
        chk({v.name, "_ovf"},  32'(ovf),  32'(v.exp_ovf));
        chk({v.name, "_rdy_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({v.name, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({v.name, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[8];
    vec_t bp_v;
    vec_t rs_v;

    initial begin
        vecs[0] = '{"add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{"sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{"sub_pos",   16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{"add_mid",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        #1;
        chk("rst_sum",   32'(sum),       32'd0);
        chk("rst_cout",  32'(cout),      32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Abort mid-RUN; the last table op left cout=1/ovf=1 so the clear is visible.
        rs_v = '{"rst_mid", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        a = rs_v.a; b = rs_v.b; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rmid_sum",  32'(sum),       32'd0);
        chk("rmid_cout", 32'(cout),      32'd0);
        chk("rmid_ovf",  32'(ovf),       32'd0);
        chk("rmid_vld",  32'(out_valid), 32'd0);
        chk("rmid_rdy",  32'(in_ready),  32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rmid_rdy_rel", 32'(in_ready),  32'd1);
        chk("rmid_no_res",  32'(out_valid), 32'd0);
        run_vec('{"post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0});

        // Backpressure: hold DONE for 5 cycles, pulse a stray in_valid with 0xAAAA.
        bp_v = '{"bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        start_and_wait(bp_v);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 16'hAAAA; b = 16'h0000; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_vld_hold", 32'(out_valid), 32'd1);
            chk("bp_sum_hold", 32'(sum),       32'h5555);
            chk("bp_rdy_low",  32'(in_ready),  32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_vld_end", 32'(out_valid), 32'd1);
        chk("bp_sum_end", 32'(sum),       32'h5555);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rdy_idle", 32'(in_ready),  32'd1);
        chk("bp_vld_drop", 32'(out_valid), 32'd0);
        for (int i = 0; i < NCH + 2; i++) begin
            step();
            chk("bp_no_capture_rdy", 32'(in_ready),  32'd1);
            chk("bp_no_capture_vld", 32'(out_valid), 32'd0);
        end
        chk("bp_sum_retained", 32'(sum), 32'h5555);

        // out_ready outside DONE must not disturb anything.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ordy_idle_rdy", 32'(in_ready), 32'd1);
        run_vec('{"after_bp", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
